// File: rtl/sang_dan_10_if.sv
// LED bank bus for the sang_dan_10 chaser: the block drives, the board (or bench) observes.
interface sang_dan_10_if;
  logic [7:0] led;

  modport master (output led);
  modport slave  (input  led);
endinterface

// File: rtl/sang_dan_10.sv
// LED chaser "sang dan" pattern 10: a prescaler paces a 32-step fill/clear
// sequence that is registered straight onto the 8 LED pins.
module sang_dan_10 #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  sang_dan_10_if.master led
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    idx_reg, idx_next;
  logic [7:0]    led_reg, led_next;
  logic          tick;

  logic [1:0]    phase;
  logic [2:0]    step;
  logic [7:0]    fill_lo;
  logic [7:0]    fill_hi;
  logic [7:0]    pattern;

  // Prescaler wraps and ticks in the same cycle.
  always_comb begin
    tick     = (cnt_reg == CW'(DIV - 1));
    cnt_next = tick ? '0 : cnt_reg + CW'(1);
    idx_next = tick ? idx_reg + 5'd1 : idx_reg;
  end

  assign phase = idx_next[4:3];
  assign step  = idx_next[2:0];

  // fill_lo: bits 0..step lit; fill_hi: bits (7-step)..7 lit.
  // The four phases are these two masks and their complements.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign fill_lo[gi] = (4'(gi) <= {1'b0, step});
      assign fill_hi[gi] = ((4'(gi) + {1'b0, step}) >= 4'd7);
    end
  endgenerate

  always_comb begin
    pattern = 8'h00;
    case (phase)
      2'd0:    pattern = fill_lo;
      2'd1:    pattern = ~fill_hi;
      2'd2:    pattern = fill_hi;
      default: pattern = ~fill_lo;
    endcase
  end

  always_comb begin
    led_next = tick ? pattern : led_reg;
  end

  // idx resets to 31 so the first tick lands on step 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= 5'd31;
      led_reg <= 8'h00;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      led_reg <= led_next;
    end
  end

  assign led.led = led_reg;

endmodule

// File: tb/tb_sang_dan_10.sv
// Self-checking bench for sang_dan_10: DIV=4 and DIV=1 instances checked every edge
// against a table-driven model of the published step sequence.
module tb_sang_dan_10;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n4 = 0;
  int   n1 = 0;

  logic [7:0] seq [32] = '{
    8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
    8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00,
    8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  sang_dan_10_if bus4 ();
  sang_dan_10_if bus1 ();

  sang_dan_10 #(.DIV(4)) dut4 (.clk(clk), .rst_n(rst_a), .led(bus4));
  sang_dan_10 #(.DIV(1)) dut1 (.clk(clk), .rst_n(rst_b), .led(bus1));

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // n = number of released edges since the last reset edge.
  function automatic logic [7:0] exp_led(input int n, input int div);
    if (n < div) return 8'h00;
    return seq[((n / div) - 1) % 32];
  endfunction

  task automatic edge_step(input logic ra, input logic rb);
    rst_a = ra;
    rst_b = rb;
    @(posedge clk);
    n4 = ra ? n4 + 1 : 0;
    n1 = rb ? n1 + 1 : 0;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      edge_step(1'b0, 1'b0);
      tests++;
      if (bus4.led !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold4 edge %0d: got %h want 00", i, bus4.led);
      end
      tests++;
      if (bus1.led !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold1 edge %0d: got %h want 00", i, bus1.led);
      end
    end
  endtask

  task automatic test_first_step();
    logic [7:0] want;
    for (int e = 1; e <= 4; e++) begin
      edge_step(1'b1, 1'b0);
      want = (e == 4) ? 8'h01 : 8'h00;
      tests++;
      if (bus4.led !== want) begin
        fails++;
        $display("FAIL first_step edge %0d: got %h want %h", e, bus4.led, want);
      end
    end
  endtask

  // Continues from led=01; checks every edge and that each value lasts exactly 4 edges.
  task automatic test_full_sequence();
    logic [7:0] prev;
    int run;
    prev = bus4.led;
    run = 1;
    for (int e = 0; e < 32 * 4; e++) begin
      edge_step(1'b1, 1'b0);
      tests++;
      if (bus4.led !== exp_led(n4, 4)) begin
        fails++;
        $display("FAIL full_seq n=%0d: got %h want %h", n4, bus4.led, exp_led(n4, 4));
      end
      if (bus4.led === prev) begin
        run++;
      end else begin
        tests++;
        if (run != 4) begin
          fails++;
          $display("FAIL hold_time value %h: held %0d edges want 4", prev, run);
        end
        prev = bus4.led;
        run = 1;
      end
    end
    tests++;
    if (bus4.led !== 8'h01) begin
      fails++;
      $display("FAIL wrap_around: got %h want 01", bus4.led);
    end
  endtask

  task automatic test_reset_mid();
    edge_step(1'b0, 1'b0);
    // led=E0 is step 28 (n in 116..119); n=119 means the next edge is a tick.
    for (int e = 0; e < 119; e++) edge_step(1'b1, 1'b0);
    tests++;
    if (bus4.led !== 8'hE0) begin
      fails++;
      $display("FAIL mid_pre: got %h want E0", bus4.led);
    end
    edge_step(1'b0, 1'b0);
    tests++;
    if (bus4.led !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: got %h want 00", bus4.led);
    end
    for (int e = 1; e <= 4; e++) begin
      edge_step(1'b1, 1'b0);
      tests++;
      if (bus4.led !== ((e == 4) ? 8'h01 : 8'h00)) begin
        fails++;
        $display("FAIL mid_restart edge %0d: got %h", e, bus4.led);
      end
    end
  endtask

  task automatic test_div1();
    logic [7:0] want [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F,
                              8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h3F};
    edge_step(1'b1, 1'b0);
    for (int e = 0; e < 10; e++) begin
      edge_step(1'b1, 1'b1);
      tests++;
      if (bus1.led !== want[e]) begin
        fails++;
        $display("FAIL div1 edge %0d: got %h want %h", e + 1, bus1.led, want[e]);
      end
    end
  endtask

  task automatic test_random();
    logic ra, rb;
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 39) != 0);
      rb = ($urandom_range(0, 29) != 0);
      edge_step(ra, rb);
      tests++;
      if (bus4.led !== exp_led(n4, 4)) begin
        fails++;
        $display("FAIL random4 i=%0d n=%0d: got %h want %h", i, n4, bus4.led, exp_led(n4, 4));
      end
      tests++;
      if (bus1.led !== exp_led(n1, 1)) begin
        fails++;
        $display("FAIL random1 i=%0d n=%0d: got %h want %h", i, n1, bus1.led, exp_led(n1, 1));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_step();
    test_full_sequence();
    test_reset_mid();
    test_div1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sang_dan_10.md
# sang_dan_10

LED chaser pattern generator ("sang dần" pattern 10) for the 8-LED board bank. A prescaler divides the 50 MHz board clock into step ticks. On each tick the block advances through a fixed 32-step fill/clear sequence and drives the result straight onto the LED pins. It is a leaf block at top level, with no data inputs beyond clock and reset.

## Interface
- `DIV`, default 25_000_000 — clock cycles per pattern step; legal range is ≥ 1. The default gives 0.5 s per step at 50 MHz. Simulation overrides it with a small value.
- `clk`  input  1  — system clock, 50 MHz (20 ns period); all logic is on the rising edge.
- `rst_n`  input  1  — reset; synchronous, active-low.
- `led`  output  8  — LED drive, 1 = lit; `led[0]` is the rightmost LED. Registered output.

## Operation
- Prescaler:
  - Counter `cnt` runs 0..DIV-1, width ceil(log2(DIV)), minimum 1 bit.
  - When `cnt == DIV-1` it wraps to 0 and asserts a one-cycle internal `tick`.
  - `tick` is asserted in the same cycle as the wrap.
- Sequencer:
  - 5-bit step index `idx` runs 0..31.
  - Each `tick` advances it; after 31 it wraps to 0.
  - `led` is loaded with `pattern(idx_next)` on the same edge.
- The sequence has four 8-step phases (hex), where phase = `idx[4:3]`:
  - A, fill LSB→MSB: 01 03 07 0F 1F 3F 7F FF
  - B, clear MSB→LSB: 7F 3F 1F 0F 07 03 01 00
  - C, fill MSB→LSB: 80 C0 E0 F0 F8 FC FE FF
  - D, clear LSB→MSB: FE FC F8 F0 E0 C0 80 00
- The sequence repeats indefinitely: after D's final 00, the next tick gives 01.
- Reset state:
  - `cnt = 0`
  - `idx = 31` (the "pre-start" position, so the first tick lands on idx 0)
  - `led = 8'h00`
- No other states or inputs. The output never takes a value outside the table.

## Timing
- Reset:
  - `rst_n` is sampled only on rising `clk`.
  - Any edge with `rst_n = 0` forces the reset state on that edge. This applies mid-step and mid-phase, and overrides a coincident `tick`.
- Release:
  - Let edge E1 be the first rising edge with `rst_n = 1`; on E1, `cnt` goes 0→1.
  - `led` becomes 01 on edge E_DIV, the DIV-th edge with `rst_n = 1`.
  - It then changes exactly every DIV cycles.
- Each `led` value is held for exactly DIV clock cycles. It never glitches between steps, because it is driven by a flop.
- DIV = 1: `tick` is asserted every cycle, and `led` steps on every edge after release.
- Full 32-step cycle = 32·DIV clocks. Value 00 appears twice per cycle (end of B and end of D), and FF appears twice (end of A and end of C).
- Latency tick→`led` = 0 cycles: the update happens on the tick edge itself.

## Test plan
- Use DIV = 4 and `clk` period 20 ns throughout.
- Reset hold: hold `rst_n = 0` for 5 edges → `led = 00` on every edge, `cnt` stays 0.
- First step: release `rst_n` → `led` stays 00 for edges 1–3 and becomes 01 on edge 4.
- Full sequence: run 32 steps, sampling `led` every 4 edges. Required order: 01,03,07,0F,1F,3F,7F,FF, 7F,3F,1F,0F,07,03,01,00, 80,C0,E0,F0,F8,FC,FE,FF, FE,FC,F8,F0,E0,C0,80,00. The 33rd sample must be 01 (wrap-around).
- Hold time: check each `led` value is stable for exactly 4 consecutive edges. There must be no intermediate values.
- Reset mid-operation: assert `rst_n = 0` for one edge while `led = E0` and coincident with a tick.
  - Required: `led = 00` on that edge.
  - Required: after release, 01 reappears on the 4th edge.
- DIV = 1 instance: release reset → `led` shows 01,03,07,… on consecutive edges, starting at the first released edge.
